// File: rtl/pmod_als_spi_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module      : pmod_als_spi_transmitter_if
// Description : SPI pin bundle between a master and the Pmod ALS sensor model.
// Revision    : 1.0 - initial release
// ============================================================================
interface pmod_als_spi_transmitter_if;
  logic cs;      // chip select, active low
  logic sck;     // serial clock, idle high
  logic sdo;     // serial data from the sensor
  logic sdo_oe;  // sensor is driving sdo

  modport master (output cs, output sck, input sdo, input sdo_oe);
  modport slave  (input cs, input sck, output sdo, output sdo_oe);
endinterface
`default_nettype wire

// File: rtl/pmod_als_spi_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : pmod_als_spi_transmitter
// Description : Peripheral-side model of the Pmod ALS (ADC081S021 framing).
//               Oversamples the master's cs/sck and shifts out a latched
//               sample framed by leading and trailing zeros, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module pmod_als_spi_transmitter #(
  parameter int LEAD_ZEROS = 3,
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_BITS = 16
) (
  input  wire logic                  clock,
  input  wire logic                  reset_n,
  input  wire logic [DATA_WIDTH-1:0] sample,
  input  wire logic                  sample_we,
  pmod_als_spi_transmitter_if.slave  spi,
  output logic                       frame_done,
  output logic                       frame_abort,
  output logic                       busy
);

  localparam int C_TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_WIDTH;
  localparam int C_CNT_W       = $clog2(FRAME_BITS + 1);
  localparam logic [C_CNT_W-1:0] C_LAST_BIT = C_CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [2:0]              r_cs_pipe;   // [0],[1] synchronizer, [2] edge delay
  logic [2:0]              r_sck_pipe;
  logic [DATA_WIDTH-1:0]   r_pending;
  logic [FRAME_BITS-1:0]   r_frame;
  logic [C_CNT_W-1:0]      r_count;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_abort;
  logic [FRAME_BITS-1:0]   w_load;
  logic                    w_cs_fall;
  logic                    w_cs_rise;
  logic                    w_sck_fall;

  // Frame image: leading zeros, pending sample, trailing zeros (if any).
  if (C_TRAIL_ZEROS > 0) begin : g_trail
    assign w_load = {{LEAD_ZEROS{1'b0}}, r_pending, {C_TRAIL_ZEROS{1'b0}}};
  end else begin : g_no_trail
    assign w_load = {{LEAD_ZEROS{1'b0}}, r_pending};
  end

  assign w_cs_fall  =  r_cs_pipe[2]  & ~r_cs_pipe[1];
  assign w_cs_rise  = ~r_cs_pipe[2]  &  r_cs_pipe[1];
  assign w_sck_fall =  r_sck_pipe[2] & ~r_sck_pipe[1];

  assign spi.sdo     = r_frame[FRAME_BITS-1];
  assign spi.sdo_oe  = r_busy;
  assign busy        = r_busy;
  assign frame_done  = r_done;
  assign frame_abort = r_abort;

  // Bring the asynchronous master pins into the clock domain; idle level is high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_pipe  <= 3'b111;
      r_sck_pipe <= 3'b111;
    end else begin
      r_cs_pipe  <= {r_cs_pipe[1:0], spi.cs};
      r_sck_pipe <= {r_sck_pipe[1:0], spi.sck};
    end
  end

  // Pending sample; only copied into the frame at frame start, so a write
  // during a frame is deferred to the next one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else if (sample_we) begin
      r_pending <= sample;
    end
  end

  // Frame sequencer: load on cs fall, shift on sck fall, abort on early cs rise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_frame <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_frame <= w_load;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // cs rise is checked first so a coincident sck fall cannot finish the frame.
          if (w_cs_rise) begin
            r_abort <= 1'b1;
            r_frame <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_sck_fall) begin
            r_count <= r_count + C_CNT_W'(1);
            if (r_count == C_LAST_BIT) begin
              r_frame <= '0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_frame <= {r_frame[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
        ST_DONE: begin
          // Extra sck edges are ignored; sdo stays low until cs returns high.
          if (w_cs_rise) begin
            r_count <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_frame <= '0;
          r_count <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pmod_als_spi_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pmod_als_spi_transmitter
// Description : Scoreboard bench; a master task drives SPI frames and queues
//               the expected capture, a monitor records sdo and pops/compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmod_als_spi_transmitter;

  logic       clock;
  logic       reset_n;
  logic [7:0] sample;
  logic       sample_we;
  logic       frame_done;
  logic       frame_abort;
  logic       busy;

  pmod_als_spi_transmitter_if spi ();

  pmod_als_spi_transmitter #(
    .LEAD_ZEROS (3),
    .DATA_WIDTH (8),
    .FRAME_BITS (16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sample      (sample),
    .sample_we   (sample_we),
    .spi         (spi.slave),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .busy        (busy)
  );

  typedef struct {
    int          n;
    logic [31:0] word;
    int          done;
    int          abort;
  } exp_t;

  exp_t       exp_q[$];
  int         vecs;
  int         errs;
  int         done_cnt;
  int         abort_cnt;
  logic [7:0] pend;   // reference model of the pending register

  initial clock = 1'b0;
  always #42 clock = ~clock;

  // Count strobes as the DUT presents them.
  always @(negedge clock) begin
    if (frame_done)  done_cnt  = done_cnt + 1;
    if (frame_abort) abort_cnt = abort_cnt + 1;
  end

  // Sensor frame: 3 leading zeros, 8-bit value, 5 trailing zeros.
  function automatic logic [15:0] frame_word(input logic [7:0] v);
    return 16'(v) * 16'd32;
  endfunction

  // Bit seen by the master before its (k+1)-th sck fall.
  function automatic logic bit_at(input logic [15:0] f, input int k);
    if (k >= 16) return 1'b0;
    return f[15-k];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vecs = vecs + 1;
    if (got !== want) begin
      errs = errs + 1;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic write_sample(input logic [7:0] v);
    sample    = v;
    sample_we = 1'b1;
    @(negedge clock);
    sample_we = 1'b0;
    pend      = v;
  endtask

  // One cs-low window with n sck falls; optional mid-frame write or reset.
  task automatic run_frame(input int n, input int wr_at, input logic [7:0] wr_val, input int rst_at);
    exp_t        e;
    logic [15:0] f;
    f       = frame_word(pend);
    e.n     = (rst_at > 0) ? rst_at : n;
    e.word  = '0;
    for (int k = 0; k < e.n; k++) e.word = {e.word[30:0], bit_at(f, k)};
    e.done  = (rst_at == 0 && n >= 16) ? 1 : 0;
    e.abort = (rst_at == 0 && n < 16) ? 1 : 0;
    exp_q.push_back(e);

    spi.cs = 1'b0;
    repeat (8) @(negedge clock);
    for (int i = 1; i <= n; i++) begin
      spi.sck = 1'b0;
      if (i == rst_at) begin
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("reset_outputs", {27'd0, spi.sdo, spi.sdo_oe, frame_done, frame_abort, busy}, 32'd0);
        pend = 8'h00;
        break;
      end
      if (i == wr_at) begin
        write_sample(wr_val);
        repeat (5) @(negedge clock);
      end else begin
        repeat (6) @(negedge clock);
      end
      spi.sck = 1'b1;
      repeat (6) @(negedge clock);
    end
    spi.sck = 1'b1;
    @(negedge clock);
    spi.cs = 1'b1;
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (16) @(negedge clock);
  endtask

  // Monitor: capture sdo at each sck fall inside a cs window, then score it.
  initial begin : monitor
    int          d0, a0, n;
    logic [31:0] bits;
    logic        oe_ok;
    exp_t        e;
    forever begin
      @(negedge spi.cs);
      d0 = done_cnt; a0 = abort_cnt; n = 0; bits = '0; oe_ok = 1'b1;
      while (spi.cs === 1'b0) begin
        @(negedge spi.sck or posedge spi.cs);
        if (spi.cs === 1'b0 && spi.sck === 1'b0) begin
          bits = {bits[30:0], spi.sdo};
          if (spi.sdo_oe !== 1'b1) oe_ok = 1'b0;
          n = n + 1;
        end
      end
      repeat (8) @(negedge clock);
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("bit_count", 32'(n), 32'(e.n));
        check("frame_bits", bits, e.word);
        check("frame_done_pulses", 32'(done_cnt - d0), 32'(e.done));
        check("frame_abort_pulses", 32'(abort_cnt - a0), 32'(e.abort));
        check("sdo_oe_in_frame", {31'd0, oe_ok}, 32'd1);
        check("idle_after_cs", {29'd0, busy, spi.sdo_oe, spi.sdo}, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    int n, wr_at, nw;
    vecs = 0; errs = 0; done_cnt = 0; abort_cnt = 0; pend = 8'h00;
    reset_n = 1'b0; sample = 8'h00; sample_we = 1'b0;
    spi.cs = 1'b1; spi.sck = 1'b1;
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("reset_state", {27'd0, spi.sdo, spi.sdo_oe, frame_done, frame_abort, busy}, 32'd0);

    write_sample(8'hA5);  run_frame(16, 0, 8'h00, 0);   // 16'h14A0
    write_sample(8'hF0);  run_frame(16, 0, 8'h00, 0);
    write_sample(8'h0F);  run_frame(16, 0, 8'h00, 0);
    write_sample(8'hC3);  run_frame(16, 5, 8'h3C, 0);   // 16'h1860, write deferred
    run_frame(16, 0, 8'h00, 0);                          // 16'h0780
    write_sample(8'h5A);  run_frame(7, 0, 8'h00, 0);    // early cs rise
    run_frame(16, 0, 8'h00, 0);                          // restarts at leading zeros
    write_sample(8'hFF);  run_frame(20, 0, 8'h00, 0);   // overrun clocks
    write_sample(8'h99);  run_frame(16, 0, 8'h00, 9);   // reset at bit 9
    run_frame(16, 0, 8'h00, 0);                          // pending cleared: 16'h0000

    for (int t = 0; t < 25; t++) begin
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) write_sample(8'($urandom));
      case ($urandom_range(0, 2))
        0:       n = 16;
        1:       n = $urandom_range(1, 15);
        default: n = $urandom_range(17, 20);
      endcase
      wr_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0;
      run_frame(n, wr_at, 8'($urandom), 0);
    end

    repeat (20) @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
